// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle for the sequential binary-to-BCD converter.
// The master side drives start/bin; the converter (slave) returns ready, done_tick and bcd.
interface bin2bcd_seq_if #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
);
  logic                    start;
  logic [BIN_WIDTH-1:0]    bin;
  logic                    ready;
  logic                    done_tick;
  logic [4*BCD_DIGITS-1:0] bcd;

  modport master (output start, bin, input ready, done_tick, bcd);
  modport slave  (input start, bin, output ready, done_tick, bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary-to-BCD converter, one input bit per clock, result held until the next conversion.
// Optional macro BIN2BCD_AUTO_START_EN: also convert automatically whenever bin differs from the last accepted value.
module bin2bcd_seq #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  bin2bcd_seq_if.slave bus
);

  localparam int DW = 4 * BCD_DIGITS;
  localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // True when BCD_DIGITS decimal digits can hold the largest BIN_WIDTH-bit value.
  function automatic bit digits_fit();
    longint max_val;
    longint pow10;
    max_val = (longint'(1) << BIN_WIDTH) - 1;
    pow10   = 1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (pow10 <= max_val) pow10 = pow10 * 10;
    end
    return pow10 > max_val;
  endfunction

  localparam bit DIGITS_OK = digits_fit();

  generate
    if (BIN_WIDTH < 1) begin : g_bad_width
      $error("bin2bcd_seq: BIN_WIDTH must be at least 1");
    end
    if (!DIGITS_OK) begin : g_bad_digits
      $error("bin2bcd_seq: BCD_DIGITS too small for BIN_WIDTH");
    end
  endgenerate

  logic [1:0]           state_reg;
  logic [BIN_WIDTH-1:0] bin_shift_reg;
  logic [DW-1:0]        digits_reg;
  logic [CW-1:0]        count_reg;
  logic [DW-1:0]        bcd_reg;
  logic [DW-1:0]        digits_adj;
  logic [DW+BIN_WIDTH-1:0] chain_next;
  logic                 start_int;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
      assign digits_adj[4*gi +: 4] = (digits_reg[4*gi +: 4] >= 4'd5) ?
                                     digits_reg[4*gi +: 4] + 4'd3 :
                                     digits_reg[4*gi +: 4];
    end
  endgenerate

  // Add-3 correction feeds the shift in the same cycle.
  assign chain_next = {digits_adj, bin_shift_reg} << 1;

`ifdef BIN2BCD_AUTO_START_EN
  logic [BIN_WIDTH-1:0] last_bin_reg;

  assign start_int = bus.start | (bus.bin != last_bin_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_bin_reg <= '0;
    end else if (state_reg == IDLE && start_int) begin
      last_bin_reg <= bus.bin;
    end
  end
`else
  assign start_int = bus.start;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      bin_shift_reg <= '0;
      digits_reg    <= '0;
      count_reg     <= '0;
      bcd_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_int) begin
            bin_shift_reg <= bus.bin;
            digits_reg    <= '0;
            count_reg     <= CW'(BIN_WIDTH - 1);
            state_reg     <= OP;
          end
        end
        OP: begin
          digits_reg    <= chain_next[DW+BIN_WIDTH-1:BIN_WIDTH];
          bin_shift_reg <= chain_next[BIN_WIDTH-1:0];
          if (count_reg == '0) begin
            bcd_reg   <= chain_next[DW+BIN_WIDTH-1:BIN_WIDTH];
            state_reg <= DONE;
          end else begin
            count_reg <= count_reg - CW'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready     = (state_reg == IDLE);
  assign bus.done_tick = (state_reg == DONE);
  assign bus.bcd       = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed + randomized bench for bin2bcd_seq; expected digits come from decimal arithmetic on the input value.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks_total = 0;
  int checks_passed = 0;

  bin2bcd_seq_if #(.BIN_WIDTH(8), .BCD_DIGITS(3)) bus ();

  bin2bcd_seq #(.BIN_WIDTH(8), .BCD_DIGITS(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start one conversion and follow it through done_tick and back to ready.
  task automatic run_conv(input logic [7:0] v, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    check({tag, "_ready_before"}, 64'(bus.ready), 64'd1);
    bus.bin = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done_tick) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_bcd"}, 64'(bus.bcd), 64'(ref_bcd(int'(v))));
    $display("conv %s: bin=%0d bcd=%03h latency=%0d", tag, v, bus.bcd, lat);
    @(negedge clk);
    check({tag, "_ready_after"}, 64'(bus.ready), 64'd1);
    check({tag, "_done_low"}, 64'(bus.done_tick), 64'd0);
  endtask

  initial begin
    int dones;
    int lat;
    int idx[$];
    logic [7:0] rv;

    bus.start = 1'b0;
    bus.bin = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.ready), 64'd1);
    check("reset_done", 64'(bus.done_tick), 64'd0);
    check("reset_bcd", 64'(bus.bcd), 64'd0);
    reset = 1'b1;

    run_conv(8'd0, "zero");
    run_conv(8'd255, "max");
    run_conv(8'd99, "n99");
    run_conv(8'd100, "n100");

    for (int v = 0; v < 256; v++) run_conv(8'(v), "sweep");
    for (int k = 0; k < 20; k++) begin
      rv = 8'($urandom_range(0, 255));
      run_conv(rv, "rand");
    end

    // Start ignored while busy; bin changes during OP do not disturb the result.
    @(negedge clk);
    bus.bin = 8'd37;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    lat = -1;
    for (int i = 0; i < 25; i++) begin
      if (i == 2) begin
        bus.bin = 8'd200;
        bus.start = 1'b1;
      end
      if (i == 3) begin
        bus.bin = 8'd37;
        bus.start = 1'b0;
      end
      if (bus.done_tick) begin
        dones++;
        if (lat < 0) lat = i;
      end
      @(negedge clk);
    end
    check("busy_done_count", 64'(dones), 64'd1);
    check("busy_latency", 64'(lat), 64'd8);
    check("busy_bcd", 64'(bus.bcd), 64'h037);
    $display("conv busy: bin=37 bcd=%03h dones=%0d", bus.bcd, dones);

    // Asynchronous reset in the middle of a conversion.
    bus.bin = 8'd255;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_done", 64'(bus.done_tick), 64'd0);
    check("midrst_ready", 64'(bus.ready), 64'd1);
    check("midrst_bcd", 64'(bus.bcd), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done_tick) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    check("midrst_bcd_held", 64'(bus.bcd), 64'd0);
    $display("conv midrst: bcd=%03h dones=%0d", bus.bcd, dones);

    // Sustained start: one conversion every BIN_WIDTH+2 cycles.
    bus.bin = 8'd42;
    bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done_tick) begin
        idx.push_back(i);
        check("hold_bcd", 64'(bus.bcd), 64'h042);
        $display("conv hold: cycle=%0d bcd=%03h", i, bus.bcd);
      end
    end
    bus.start = 1'b0;
    check("hold_count", 64'(idx.size()), 64'd3);
    if (idx.size() == 3) begin
      check("hold_first", 64'(idx[0]), 64'd8);
      check("hold_period1", 64'(idx[1] - idx[0]), 64'd10);
      check("hold_period2", 64'(idx[2] - idx[1]), 64'd10);
    end
    repeat (12) @(negedge clk);

`ifdef BIN2BCD_AUTO_START_EN
    // Auto-start: conversions only when bin changes.
    reset = 1'b0;
    bus.bin = 8'd0;
    @(negedge clk);
    reset = 1'b1;
    idx.delete();
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) bus.bin = 8'd17;
      if (i == 25) bus.bin = 8'd17;
      if (i == 40) bus.bin = 8'd18;
      @(negedge clk);
      if (bus.done_tick) begin
        dones++;
        if (dones == 1) check("auto_bcd1", 64'(bus.bcd), 64'h017);
        if (dones == 2) check("auto_bcd2", 64'(bus.bcd), 64'h018);
        $display("conv auto: bcd=%03h", bus.bcd);
      end
    end
    check("auto_count", 64'(dones), 64'd2);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
